// File: rtl/ipic_pkg.sv
// rtl/ipic_pkg.sv - shared IPIC lite transaction types and arbiter state encoding
package ipic_pkg;

    localparam logic [2:0] IPIC_TYPE_SINGLE_RD = 3'd2;
    localparam logic [2:0] IPIC_TYPE_SINGLE_WR = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_COOL  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational round-robin pick starting just above rr_ptr
module rr_arbiter_core #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [2:0]         rr_ptr,
    output logic [2:0]         grant_idx,
    output logic               any_valid
);

    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_any;
    logic       lo_any;

    // Lowest set bit above rr_ptr wins; otherwise wrap to the lowest set bit at or below it.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(rr_ptr)) begin
                    hi_idx = 3'(i);
                    hi_any = 1'b1;
                end else begin
                    lo_idx = 3'(i);
                    lo_any = 1'b1;
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
        any_valid = hi_any | lo_any;
    end

endmodule

// File: rtl/ipic_lite_arbiter.sv
// rtl/ipic_lite_arbiter.sv - round-robin sharing of one single-beat IPIC lite master
// Optional watchdog on the ISSUE state is built when IPIC_ARB_TIMEOUT_EN is defined.
module ipic_lite_arbiter
    import ipic_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              resp_done,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            resp_err,
    output logic                            busy,
    output logic [2:0]                      grant_id,
    output logic [2:0]                      ipic_type,
    output logic                            ipic_start,
    input  logic                            ipic_done,
    output logic [ADDR_WIDTH-1:0]           read_addr,
    output logic [ADDR_WIDTH-1:0]           write_addr,
    output logic [DATA_WIDTH-1:0]           write_data,
    input  logic [DATA_WIDTH-1:0]           single_read_data
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ipic_lite_arbiter: unsupported parameter set");
    end

    arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0]    req_ack_q, req_ack_d, resp_done_q, resp_done_d;
    logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d, pick_oh;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d, write_data_q, write_data_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d, write_addr_q, write_addr_d;
    logic [2:0]            grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d;
    logic [2:0]            ipic_type_q, ipic_type_d;
    logic                  busy_q, busy_d, ipic_start_q, ipic_start_d, wr_q, wr_d;
    logic [2:0]            pick_idx;
    logic                  pick_any, sel_write, finish;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, fin_rdata;

`ifdef IPIC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          resp_err_q, resp_err_d;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_core (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // One-hot select avoids indexing the request vectors with a wider-than-needed index.
    always_comb begin
        pick_oh   = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_oh[i] = (3'(i) == pick_idx);
            if (pick_oh[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ack_d    = '0;
        resp_done_d  = '0;
        resp_rdata_d = resp_rdata_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_oh_d     = gnt_oh_q;
        wr_d         = wr_q;
        ipic_type_d  = ipic_type_q;
        ipic_start_d = ipic_start_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        finish       = 1'b0;
        fin_rdata    = '0;
`ifdef IPIC_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef IPIC_ARB_TIMEOUT_EN
                tmo_d      = '0;
                resp_err_d = 1'b0;
`endif
                if (pick_any) begin
                    req_ack_d    = pick_oh;
                    gnt_oh_d     = pick_oh;
                    rr_ptr_d     = pick_idx;
                    grant_id_d   = pick_idx;
                    wr_d         = sel_write;
                    ipic_start_d = 1'b1;
                    ipic_type_d  = sel_write ? IPIC_TYPE_SINGLE_WR : IPIC_TYPE_SINGLE_RD;
                    read_addr_d  = sel_write ? '0 : sel_addr;
                    write_addr_d = sel_write ? sel_addr : '0;
                    write_data_d = sel_write ? sel_wdata : '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ipic_done) begin
                    finish    = 1'b1;
                    fin_rdata = wr_q ? '0 : single_read_data;
                end
`ifdef IPIC_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    finish     = 1'b1;
                    resp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
                if (finish) begin
                    ipic_start_d = 1'b0;
                    ipic_type_d  = '0;
                    read_addr_d  = '0;
                    write_addr_d = '0;
                    write_data_d = '0;
                    resp_rdata_d = fin_rdata;
                    resp_done_d  = gnt_oh_q;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_COOL;
            // Wait for the master to drop done so it is idle before the next start.
            ST_COOL: if (!ipic_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_ack_q    <= '0;
            resp_done_q  <= '0;
            resp_rdata_q <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= 3'(NUM_REQ - 1);
            gnt_oh_q     <= '0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            ipic_type_q  <= '0;
            ipic_start_q <= 1'b0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
`ifdef IPIC_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_ack_q    <= req_ack_d;
            resp_done_q  <= resp_done_d;
            resp_rdata_q <= resp_rdata_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_oh_q     <= gnt_oh_d;
            wr_q         <= wr_d;
            busy_q       <= busy_d;
            ipic_type_q  <= ipic_type_d;
            ipic_start_q <= ipic_start_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
`ifdef IPIC_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign req_ack    = req_ack_q;
    assign resp_done  = resp_done_q;
    assign resp_rdata = resp_rdata_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign ipic_type  = ipic_type_q;
    assign ipic_start = ipic_start_q;
    assign read_addr  = read_addr_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

endmodule

// File: doc/ipic_lite_arbiter.md
Name: ipic_lite_arbiter

Overview:
- Round-robin arbiter that shares one single-beat IPIC lite master (the single read/write transaction state machine) among NUM_REQ user-logic requesters.
- Latches the winner's command, drives the master's ipic_type/ipic_start/address/data, waits for ipic_done and routes the completion and read data back to the winner.
- Sits between the TDMA middleware client blocks and the IPIC lite state machine.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ADDR_WIDTH, 32, IPIC address width.
- DATA_WIDTH, 32, IPIC data width; the IPIC lite master supports 32 only.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with IPIC_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request level.
- req_write  in  NUM_REQ  1 = single write, 0 = single read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; command latched.
- resp_done  out  NUM_REQ  one-hot, 1-cycle pulse; transaction finished.
- resp_rdata  out  DATA_WIDTH  read data; valid while resp_done is high.
- resp_err  out  1  timeout flag, qualified by resp_done.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.
- ipic_type  out  3  2 = single read, 3 = single write.
- ipic_start  out  1  transaction request to the IPIC master.
- ipic_done  in  1  completion pulse from the IPIC master.
- read_addr  out  ADDR_WIDTH  read address to the master.
- write_addr  out  ADDR_WIDTH  write address to the master.
- write_data  out  DATA_WIDTH  write data to the master.
- single_read_data  in  DATA_WIDTH  read result from the master.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rr_ptr = NUM_REQ-1, so requester 0 has highest priority first.
- States:
  - IDLE: if any req_valid is set, grant the first set bit searching upward from rr_ptr+1 modulo NUM_REQ. In the same edge: pulse req_ack[g]; latch write flag, address and data; set rr_ptr = g and grant_id = g; go to ISSUE.
  - ISSUE: ipic_start = 1; ipic_type = 3 if write, else 2. For writes, write_addr = latched address, write_data = latched data, read_addr = 0. For reads, read_addr = latched address and write_addr/write_data = 0. All held stable while in ISSUE. When ipic_done = 1: ipic_start <= 0, capture single_read_data (0 for writes) into resp_rdata, go to RESP.
  - RESP: resp_done[grant_id] = 1 for exactly one cycle; go to COOL.
  - COOL: ipic_start stays 0 for at least one cycle. Stay until ipic_done = 0, then go to IDLE. This guarantees the master has returned to its idle state before the next start.
- Latency: req_valid seen in IDLE at cycle 0 gives req_ack and ipic_start at cycle 1. ipic_done seen at cycle n gives resp_done at cycle n+1. Minimum gap between back-to-back grants is 3 cycles.
- Requesters may drop or change req_valid and payload after req_ack. A requester must not expect its payload to be re-sampled.
- If req_valid drops before grant, the request is ignored; no ack is issued.
- Simultaneous requests: exactly one grant per IDLE visit. Fairness: any continuously asserted request is granted within NUM_REQ grants.
- ipic_done while not in ISSUE is ignored.
- A new req_valid from the requester currently in RESP or COOL is arbitrated normally in the next IDLE.
- Asynchronous reset mid-transaction: drop ipic_start immediately, no resp_done, return to IDLE. The master is reset by the same reset_n.
- grant_id is zero-extended to 3 bits.

Optional Feature:
- Macro IPIC_ARB_TIMEOUT_EN.
- When defined: a counter runs in ISSUE. If it reaches TIMEOUT_CYCLES without ipic_done, drop ipic_start, set resp_rdata = 0 and resp_err = 1, then go to RESP. resp_err clears on the next IDLE.
- When not defined: no counter is built, resp_err is tied to 0, and ISSUE waits indefinitely.

Decomposition:
- Shared package ipic_pkg:
  - IPIC type constants IPIC_TYPE_SINGLE_RD = 2, IPIC_TYPE_SINGLE_WR = 3.
  - Arbiter state encoding: IDLE = 0, ISSUE = 1, RESP = 2, COOL = 3.
- One sub-module, rr_arbiter_core: combinational round-robin priority pick from req_valid and rr_ptr. Returns a grant index and an any-valid flag.

Test Plan:
- Single read: req_valid[1] = 1, req_addr[1] = 0x4000_0010; master model returns done after 5 cycles with data 0xDEADBEEF. Required: req_ack = 0010 at cycle 1, ipic_type = 2, read_addr = 0x4000_0010, resp_done = 0010 with resp_rdata = 0xDEADBEEF.
- Single write: requester 3 writes 0x1234_5678 to 0x4000_0020. Required: ipic_type = 3, write_addr and write_data match, resp_done = 1000, resp_rdata = 0.
- All four requesters held high for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3 and no ipic_start re-issue.
- ipic_done held high for 2 cycles. Required: COOL holds until done is low, and exactly one transaction and one resp_done occur.
- Assert reset_n low while in ISSUE. Required: ipic_start, busy and all outputs become 0 asynchronously, and no resp_done is produced.
- With IPIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the master never sends done. Required: ipic_start drops after 16 cycles, and resp_done pulses with resp_err = 1.
